// File: rtl/prio_enc_rr.sv
// Registered N-way priority encoder with fixed (MSB-wins) and round-robin modes.
// The result sits in a one-deep valid/ready output stage that a consumer may stall.
module prio_enc_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant,
  output logic [W-1:0] rr_ptr
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] grant_q, grant_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic [W:0]   pos;
  logic         accept;
  logic         load;

  assign accept = (state_q == FULL) && out_ready;
  assign load   = ((state_q == EMPTY) || out_ready) && (req != '0);

  // Winner search. Fixed mode: the last hit of an ascending scan is the highest
  // index. Round-robin: a descending scan over offsets leaves the nearest hit
  // at or after ptr_q.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fixed_idx = '0;
    rr_idx    = '0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i[W-1:0]]) fixed_idx = W'(i);
    end
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + k[W:0];
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (req[pos[W-1:0]]) rr_idx = pos[W-1:0];
    end
  end

  // Accept and load may coincide; load wins on state, and the search above has
  // already used the pre-update pointer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (accept) begin
      state_d = EMPTY;
      ptr_d   = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
    end
    if (load) begin
      state_d = FULL;
      idx_d   = mode ? rr_idx : fixed_idx;
      grant_d = N'(1) << idx_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_idx   = idx_q;
  assign out_grant = grant_q;
  assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Bench for prio_enc_rr: N=8 and N=16 instances against a behavioural model,
// directed scenarios first, then randomized traffic.
module tb_prio_enc_rr;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [7:0]  req8;
  logic        mode8, rdy8;
  logic        valid8;
  logic [2:0]  idx8, ptr8;
  logic [7:0]  grant8;

  logic [15:0] req16;
  logic        mode16, rdy16;
  logic        valid16;
  logic [3:0]  idx16, ptr16;
  logic [15:0] grant16;

  int n_cmp = 0;
  int n_err = 0;

  bit mv[2];
  int midx[2];
  int mptr[2];
  int nn[2] = '{8, 16};

  always #5 clk = ~clk;

  prio_enc_rr #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .out_ready(rdy8),
    .out_valid(valid8), .out_idx(idx8), .out_grant(grant8), .rr_ptr(ptr8)
  );

  prio_enc_rr #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .mode(mode16), .out_ready(rdy16),
    .out_valid(valid16), .out_idx(idx16), .out_grant(grant16), .rr_ptr(ptr16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit has_bit(input logic [63:0] r, input int j);
    return ((r >> j) & 64'd1) != 64'd0;
  endfunction

  function automatic int fixed_win(input logic [63:0] r, input int n);
    for (int i = n - 1; i >= 0; i--) if (has_bit(r, i)) return i;
    return 0;
  endfunction

  function automatic int rr_win(input logic [63:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) if (has_bit(r, (p + k) % n)) return (p + k) % n;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; midx[i] = 0; mptr[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [63:0] r, input bit m, input bit rdy);
    bit fire;
    bit can_take;
    int old_idx;
    fire     = mv[i] && rdy;
    can_take = !mv[i] || rdy;
    old_idx  = midx[i];
    if (can_take) begin
      if (r != 64'd0) begin
        midx[i] = m ? rr_win(r, mptr[i], nn[i]) : fixed_win(r, nn[i]);
        mv[i]   = 1'b1;
      end else begin
        mv[i] = 1'b0;
      end
    end
    if (fire) mptr[i] = (old_idx + 1) % nn[i];
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare both instances 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step(0, 64'(req8), mode8, rdy8);
    model_step(1, 64'(req16), mode16, rdy16);
    #1;
    check("v8", 64'(valid8), 64'(mv[0]));
    check("ptr8", 64'(ptr8), 64'(mptr[0]));
    if (mv[0]) begin
      check("idx8", 64'(idx8), 64'(midx[0]));
      check("gnt8", 64'(grant8), 64'd1 << midx[0]);
    end
    check("v16", 64'(valid16), 64'(mv[1]));
    check("ptr16", 64'(ptr16), 64'(mptr[1]));
    if (mv[1]) begin
      check("idx16", 64'(idx16), 64'(midx[1]));
      check("gnt16", 64'(grant16), 64'd1 << midx[1]);
    end
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    check("arst_v8", 64'(valid8), 64'd0);
    check("arst_ptr8", 64'(ptr8), 64'd0);
    check("arst_v16", 64'(valid16), 64'd0);
    check("arst_ptr16", 64'(ptr16), 64'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  logic [7:0] seen;

  initial begin
    rst_n = 1'b0;
    req8  = '0; mode8  = 1'b0; rdy8  = 1'b1;
    req16 = '0; mode16 = 1'b1; rdy16 = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_v8", 64'(valid8), 64'd0);
    check("rst_idx8", 64'(idx8), 64'd0);
    check("rst_gnt8", 64'(grant8), 64'd0);
    check("rst_ptr8", 64'(ptr8), 64'd0);
    check("rst_v16", 64'(valid16), 64'd0);
    rst_n = 1'b1;

    repeat (5) step();

    // Fixed priority.
    req8 = 8'h2C; step();
    check("fix_idx", 64'(idx8), 64'd5);
    check("fix_gnt", 64'(grant8), 64'h20);
    req8 = 8'h01; step();
    check("fix_idx0", 64'(idx8), 64'd0);
    check("fix_gnt0", 64'(grant8), 64'h01);

    // Stall: held result ignores req until accepted.
    req8 = 8'h80; step();
    check("ld_idx7", 64'(idx8), 64'd7);
    rdy8 = 1'b0; req8 = 8'h03;
    repeat (4) begin
      step();
      check("stall_v", 64'(valid8), 64'd1);
      check("stall_idx", 64'(idx8), 64'd7);
    end
    rdy8 = 1'b1; step();
    check("unstall_idx", 64'(idx8), 64'd1);

    // Leave the pointer non-zero, then reset while FULL.
    req8 = 8'h01; step();
    check("pre_rst_ptr", 64'(ptr8), 64'd2);
    async_reset();

    // Round-robin over all requesters. Accept+load searches from the
    // pre-update pointer, so every index is still granted, each twice.
    mode8 = 1'b1; req8 = 8'hFF; seen = '0;
    step();
    check("rr_first", 64'(idx8), 64'd0);
    seen = seen | (8'd1 << idx8);
    repeat (15) begin
      step();
      check("rr_v", 64'(valid8), 64'd1);
      seen = seen | (8'd1 << idx8);
    end
    check("rr_cov", 64'(seen), 64'hFF);
    req8 = 8'h00; step();

    // Wrapped scan from pointer 6.
    mode8 = 1'b0; req8 = 8'h20; step();
    req8 = 8'h00; step();
    check("wrap_ptr6", 64'(ptr8), 64'd6);
    mode8 = 1'b1; req8 = 8'h06; step();
    check("wrap_idx1", 64'(idx8), 64'd1);
    req8 = 8'h00; step();
    check("wrap_ptr2", 64'(ptr8), 64'd2);
    req8 = 8'h06; step();
    check("wrap_idx2", 64'(idx8), 64'd2);
    req8 = 8'h00; step();

    // N=16 alternating load/accept with requesters 0 and 15.
    for (int r = 0; r < 4; r++) begin
      req16 = 16'h8001; step();
      check("n16_idx", 64'(idx16), (r % 2 == 0) ? 64'd0 : 64'd15);
      req16 = 16'h0000; step();
      check("n16_ptr", 64'(ptr16), (r % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Randomized traffic on both instances.
    for (int t = 0; t < 400; t++) begin
      req8   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom) & 8'($urandom);
      mode8  = 1'($urandom);
      rdy8   = ($urandom_range(0, 3) != 0);
      req16  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom) & 16'($urandom);
      mode16 = 1'($urandom);
      rdy16  = ($urandom_range(0, 3) != 0);
      step();
      if (t == 200) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
